// File: rtl/dspl_arbiter.sv
// Three-requester, fixed-priority owner arbiter for an 8-digit display, with hold time and per-owner blink.
// One-cycle registered latency from req/data to grant/d; no backpressure, and lower requesters wait for release.
module dspl_arbiter #(
  parameter int HOLD_CYCLES  = 100_000_000,
  parameter int BLINK_CYCLES = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [47:0] data0,
  input  logic [47:0] data1,
  input  logic [47:0] data2,
  input  logic [2:0]  blink,
  output logic [2:0]  grant,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [BW-1:0] PHASE_MAX = BW'(BLINK_CYCLES - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state;
  logic [2:0]     grant_q;
  logic [HW-1:0]  hold_cnt;
  logic [BW-1:0]  phase;
  logic           blink_on;
  logic           blink_en;
  logic [47:0]    payload;
  logic [47:0]    d_q;

  logic [2:0]     above;
  logic [2:0]     higher;
  logic           owner_req;
  logic           hold_done;
  logic [2:0]     grant_nxt;
  logic           load;
  logic           live;
  state_t         state_nxt;
  logic [HW-1:0]  hold_nxt;
  logic [BW-1:0]  phase_nxt;
  logic           on_nxt;
  logic           blink_en_nxt;
  logic [47:0]    payload_nxt;

  function automatic logic [2:0] pick(input logic [2:0] r);
    if (r[2]) return 3'b100;
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [47:0] sel_data(input logic [2:0] g, input logic [47:0] a,
                                           input logic [47:0] b, input logic [47:0] c);
    return ({48{g[0]}} & a) | ({48{g[1]}} & b) | ({48{g[2]}} & c);
  endfunction

  // Blink "off" blanks every digit by clearing its enable bit; value and dot pass through.
  function automatic logic [47:0] apply_blink(input logic [47:0] p, input logic on);
    logic [47:0] r;
    r = p;
    for (int k = 0; k < 8; k++) r[6*k+5] = p[6*k+5] & on;
    return r;
  endfunction

  // Bits strictly above the current one-hot owner.
  assign above     = {grant_q[1] | grant_q[0], grant_q[0], 1'b0};
  assign higher    = req & above;
  assign owner_req = |(req & grant_q);
  assign hold_done = (hold_cnt == HOLD_MAX);

  always_comb begin
    grant_nxt = grant_q;
    load      = 1'b0;
    live      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = pick(req);
          load      = 1'b1;
        end
      end
      OWN: begin
        if (|higher) begin
          grant_nxt = pick(higher);
          load      = 1'b1;
        end else if (owner_req) begin
          live = 1'b1;
        end else if (hold_done) begin
          // Owner bit is clear and nothing is above it, so only lower requesters remain.
          grant_nxt = pick(req);
          load      = |req;
        end
      end
      default: grant_nxt = 3'b000;
    endcase
  end

  assign state_nxt = (|grant_nxt) ? OWN : IDLE;

  always_comb begin
    hold_nxt     = hold_cnt;
    phase_nxt    = phase;
    on_nxt       = blink_on;
    blink_en_nxt = blink_en;
    payload_nxt  = payload;
    if (load) begin
      hold_nxt     = '0;
      phase_nxt    = '0;
      on_nxt       = 1'b1;
      blink_en_nxt = |(blink & grant_nxt);
      payload_nxt  = sel_data(grant_nxt, data0, data1, data2);
    end else if (state_nxt == OWN) begin
      if (!hold_done) hold_nxt = hold_cnt + 1'b1;
      if (blink_en) begin
        if (phase == PHASE_MAX) begin
          phase_nxt = '0;
          on_nxt    = ~blink_on;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      if (live) payload_nxt = sel_data(grant_q, data0, data1, data2);
    end else begin
      hold_nxt     = '0;
      phase_nxt    = '0;
      on_nxt       = 1'b1;
      blink_en_nxt = 1'b0;
      payload_nxt  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= 3'b000;
      hold_cnt <= '0;
      phase    <= '0;
      blink_on <= 1'b1;
      blink_en <= 1'b0;
      payload  <= '0;
      d_q      <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      hold_cnt <= hold_nxt;
      phase    <= phase_nxt;
      blink_on <= on_nxt;
      blink_en <= blink_en_nxt;
      payload  <= payload_nxt;
      d_q      <= (state_nxt == OWN) ? apply_blink(payload_nxt, on_nxt) : 48'd0;
    end
  end

  assign grant = grant_q;
  assign d1 = d_q[5:0];
  assign d2 = d_q[11:6];
  assign d3 = d_q[17:12];
  assign d4 = d_q[23:18];
  assign d5 = d_q[29:24];
  assign d6 = d_q[35:30];
  assign d7 = d_q[41:36];
  assign d8 = d_q[47:42];

  grant_onehot: assert property (@(posedge clock) $onehot0(grant_q));

endmodule

// File: tb/tb_dspl_arbiter.sv
// Directed bench for dspl_arbiter with HOLD_CYCLES=8 and BLINK_CYCLES=4.
module tb_dspl_arbiter;

  localparam logic [47:0] D0   = 48'h1234_5678_9ABC;
  localparam logic [47:0] D0B  = 48'hAAAA_5555_CCCC;
  localparam logic [47:0] D1   = 48'hFEDC_BA98_7654;
  localparam logic [47:0] D1B  = 48'h0123_4567_89AB;
  localparam logic [47:0] D2   = 48'h0F0F_A5A5_3C3C;
  localparam logic [47:0] D1BL = {36'h123456789, 6'b111111, 6'b101010};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req   = 3'b000;
  logic [2:0]  blink = 3'b000;
  logic [47:0] data0 = D0;
  logic [47:0] data1 = D1;
  logic [47:0] data2 = D2;
  logic [2:0]  grant;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [47:0] dv;

  int checks = 0;
  int errors = 0;

  assign dv = {d8, d7, d6, d5, d4, d3, d2, d1};

  always #5 clock = ~clock;

  dspl_arbiter #(.HOLD_CYCLES(8), .BLINK_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .blink(blink),
    .grant(grant),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = 3'b000;
    blink = 3'b000;
    data0 = D0;
    data1 = D1;
    data2 = D2;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = 3'b111;
    tick();
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
    checks++;
    if (dv !== 48'd0) begin errors++; $display("FAIL reset_d: got %h want 0", dv); end
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 3'b100) begin errors++; $display("FAIL reset_release_grant: got %b want 100", grant); end
  endtask

  task automatic test_priority;
    do_reset();
    tick();
    checks++;
    if (dv !== 48'd0) begin errors++; $display("FAIL idle_blank: got %h want 0", dv); end
    req = 3'b011;
    tick();
    checks++;
    if (grant !== 3'b010) begin errors++; $display("FAIL prio_grant: got %b want 010", grant); end
    checks++;
    if (dv !== D1) begin errors++; $display("FAIL prio_data: got %h want %h", dv, D1); end
    data1 = D1B;
    tick();
    checks++;
    if (dv !== D1B) begin errors++; $display("FAIL live_data: got %h want %h", dv, D1B); end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (grant !== 3'b010) begin errors++; $display("FAIL lower_no_preempt k=%0d: got %b want 010", k, grant); end
    end
  endtask

  task automatic test_hold;
    do_reset();
    req = 3'b001;
    tick();
    checks++;
    if (grant !== 3'b001 || dv !== D0) begin errors++; $display("FAIL hold_grant: got %b/%h want 001/%h", grant, dv, D0); end
    tick();
    tick();
    req   = 3'b000;
    data0 = D0B;
    for (int k = 3; k <= 8; k++) begin
      tick();
      checks++;
      if (grant !== 3'b001 || dv !== D0) begin
        errors++; $display("FAIL hold_frozen c%0d: got %b/%h want 001/%h", k, grant, dv, D0);
      end
    end
    tick();
    checks++;
    if (grant !== 3'b000 || dv !== 48'd0) begin errors++; $display("FAIL hold_release: got %b/%h want 000/0", grant, dv); end
  endtask

  task automatic test_preempt;
    do_reset();
    req = 3'b001;
    tick();
    tick();
    tick();
    tick();
    req = 3'b101;
    tick();
    checks++;
    if (grant !== 3'b100 || dv !== D2) begin errors++; $display("FAIL preempt_grant: got %b/%h want 100/%h", grant, dv, D2); end
    req = 3'b001;
    for (int k = 5; k <= 12; k++) begin
      tick();
      checks++;
      if (grant !== 3'b100 || dv !== D2) begin
        errors++; $display("FAIL preempt_hold c%0d: got %b/%h want 100/%h", k, grant, dv, D2);
      end
    end
    tick();
    checks++;
    if (grant !== 3'b001 || dv !== D0) begin errors++; $display("FAIL preempt_return: got %b/%h want 001/%h", grant, dv, D0); end
  endtask

  task automatic test_drop_and_rise;
    do_reset();
    req = 3'b001;
    tick();
    tick();
    req = 3'b010;
    tick();
    checks++;
    if (grant !== 3'b010 || dv !== D1) begin errors++; $display("FAIL drop_rise: got %b/%h want 010/%h", grant, dv, D1); end
  endtask

  task automatic test_blink;
    logic [5:0] e1;
    logic [5:0] e2;
    do_reset();
    data1 = D1BL;
    blink = 3'b010;
    req   = 3'b010;
    for (int k = 0; k < 12; k++) begin
      tick();
      e1 = (((k / 4) % 2) == 0) ? 6'b101010 : 6'b001010;
      e2 = (((k / 4) % 2) == 0) ? 6'b111111 : 6'b011111;
      checks++;
      if (d1 !== e1 || d2 !== e2) begin
        errors++; $display("FAIL blink c%0d: got %b/%b want %b/%b", k, d1, d2, e1, e2);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req = 3'b100;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (grant !== 3'b000 || dv !== 48'd0) begin errors++; $display("FAIL midreset: got %b/%h want 000/0", grant, dv); end
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 3'b100 || dv !== D2) begin errors++; $display("FAIL midreset_regrant: got %b/%h want 100/%h", grant, dv, D2); end
  endtask

  task automatic test_reassert;
    do_reset();
    req = 3'b001;
    for (int k = 0; k <= 5; k++) tick();
    req   = 3'b000;
    data0 = D0B;
    for (int k = 6; k <= 7; k++) begin
      tick();
      checks++;
      if (grant !== 3'b001 || dv !== D0) begin
        errors++; $display("FAIL reassert_frozen c%0d: got %b/%h want 001/%h", k, grant, dv, D0);
      end
    end
    req = 3'b001;
    for (int k = 8; k <= 10; k++) begin
      tick();
      checks++;
      if (grant !== 3'b001 || dv !== D0B) begin
        errors++; $display("FAIL reassert_live c%0d: got %b/%h want 001/%h", k, grant, dv, D0B);
      end
    end
    req = 3'b000;
    tick();
    checks++;
    if (grant !== 3'b000 || dv !== 48'd0) begin errors++; $display("FAIL reassert_release: got %b/%h want 000/0", grant, dv); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_priority();
    test_hold();
    test_preempt();
    test_drop_and_rise();
    test_blink();
    test_reset_mid();
    test_reassert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
